// File: rtl/gear_select_unit.sv
// Keypad-to-gear selector: per-key 2-FF sync + debounce, priority arbitration, speed/brake interlocks.
// Raw key edge reaches gear_code/shift_ack 3 + DEBOUNCE_CYCLES cycles later; safe_rst_req after HOLD_CYCLES of combination.
`timescale 1ns/1ps
module gear_select_unit #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int HOLD_CYCLES       = 100000000,
  parameter int NUM_FWD           = 5,
  parameter int SPD_W             = 8,
  parameter int DOWNSHIFT_MAX_SPD = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_p,
  input  logic             key_r,
  input  logic             key_n,
  input  logic             key_d,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             brake,
  input  logic [SPD_W-1:0] speed,
  input  logic             obd_mode,
  output logic [3:0]       gear_code,
  output logic [3:0]       fwd_gear,
  output logic             shift_ack,
  output logic             shift_rej,
  output logic             safe_rst_req
);

  typedef enum logic [3:0] {
    GEAR_P = 4'd3,
    GEAR_R = 4'd6,
    GEAR_N = 4'd9,
    GEAR_D = 4'd12
  } gear_e;

  localparam int K_P  = 0;
  localparam int K_R  = 1;
  localparam int K_N  = 2;
  localparam int K_D  = 3;
  localparam int K_UP = 4;
  localparam int K_DN = 5;

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_SAT  = HW'(HOLD_CYCLES);
  localparam logic [3:0]     FWD_MAX   = 4'(NUM_FWD);

  logic [5:0]     raw_keys, sync1_q, sync2_q, db_q, db_dly_q, press_ev;
  logic [DBW-1:0] db_cnt_q [6];
  gear_e          gear_q, gear_d, target;
  logic [3:0]     fwd_q, fwd_d;
  logic           ack_q, ack_d, rej_q, rej_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           sreq_q, sreq_d;
  logic           spd_zero, spd_dn_ok, combo;
  logic           req_vld, req_ok, pos_req;

  assign raw_keys  = {key_down, key_up, key_d, key_n, key_r, key_p};
  assign spd_zero  = (speed == '0);
  assign spd_dn_ok = (int'(speed) <= DOWNSHIFT_MAX_SPD);
  assign combo     = db_q[K_N] && brake && spd_zero && (gear_q == GEAR_P) && obd_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 6; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw_keys;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int i = 0; i < 6; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Holding N in P for the service combination must not shift to N, so that event is dropped there.
  always_comb begin
    press_ev = db_q & ~db_dly_q;
    if (obd_mode && (gear_q == GEAR_P)) press_ev[K_N] = 1'b0;
  end

  always_comb begin
    target  = gear_q;
    pos_req = 1'b0;
    req_vld = 1'b1;
    req_ok  = 1'b0;
    gear_d  = gear_q;
    fwd_d   = fwd_q;
    if (press_ev[K_P]) begin
      target  = GEAR_P;
      pos_req = 1'b1;
    end else if (press_ev[K_R]) begin
      target  = GEAR_R;
      pos_req = 1'b1;
    end else if (press_ev[K_N]) begin
      target  = GEAR_N;
      pos_req = 1'b1;
    end else if (press_ev[K_D]) begin
      target  = GEAR_D;
      pos_req = 1'b1;
    end else if (press_ev[K_UP]) begin
      req_ok = (gear_q == GEAR_D) && (fwd_q < FWD_MAX);
      if (req_ok) fwd_d = fwd_q + 4'd1;
    end else if (press_ev[K_DN]) begin
      req_ok = (gear_q == GEAR_D) && (fwd_q > 4'd1) && spd_dn_ok;
      if (req_ok) fwd_d = fwd_q - 4'd1;
    end else begin
      req_vld = 1'b0;
    end

    // Re-selecting the current position is acknowledged without touching state or interlocks.
    if (pos_req) begin
      if (target == gear_q) begin
        req_ok = 1'b1;
      end else begin
        req_ok = brake || (gear_q != GEAR_P);
        case (target)
          GEAR_P:  req_ok = req_ok && spd_zero;
          GEAR_R:  req_ok = req_ok && spd_zero && brake;
          GEAR_D:  req_ok = req_ok && brake && (spd_zero || (gear_q != GEAR_R));
          default: ;
        endcase
        if (req_ok) begin
          gear_d = target;
          fwd_d  = (target == GEAR_D) ? 4'd1 : 4'd0;
        end
      end
    end
    ack_d = req_vld && req_ok;
    rej_d = req_vld && !req_ok;
  end

  // Counter parks at HOLD_SAT after the pulse so a continued hold cannot fire again.
  always_comb begin
    hold_d = '0;
    sreq_d = 1'b0;
    if (combo) begin
      if (hold_q == HOLD_LAST) begin
        hold_d = HOLD_SAT;
        sreq_d = 1'b1;
      end else if (hold_q == HOLD_SAT) begin
        hold_d = hold_q;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gear_q <= GEAR_P;
      fwd_q  <= 4'd0;
      ack_q  <= 1'b0;
      rej_q  <= 1'b0;
      hold_q <= '0;
      sreq_q <= 1'b0;
    end else begin
      gear_q <= gear_d;
      fwd_q  <= fwd_d;
      ack_q  <= ack_d;
      rej_q  <= rej_d;
      hold_q <= hold_d;
      sreq_q <= sreq_d;
    end
  end

  assign gear_code    = gear_q;
  assign fwd_gear     = fwd_q;
  assign shift_ack    = ack_q;
  assign shift_rej    = rej_q;
  assign safe_rst_req = sreq_q;

endmodule
